apb_event_sink: RTL and testbench
=================================

# apb_event_sink

APB3 completer that terminates the event-notification writes issued by the event-to-APB requester. It decodes the three event windows (A at 0xABBA_0000, B at 0xBAFF_0000, C at 0xCAFE_0000), stores the last written payload per event, and keeps a saturating count per event. Wait states are inserted according to a parameter, and undecoded accesses return an error. It sits directly downstream of the requester on the same APB segment and serves as both the system endpoint and the bench's reference completer.

## Interface
- WAIT_CYCLES, 1, number of access-phase cycles with pready low before completion (0..15).
- CNT_W, 16, width of each per-event counter (1..32).
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- apb_psel_i  in  1  APB select.
- apb_penable_i  in  1  APB enable (access phase).
- apb_paddr_i  in  32  APB address.
- apb_pwrite_i  in  1  1 = write, 0 = read.
- apb_pwdata_i  in  32  write data.
- apb_pready_o  out  1  transfer complete.
- apb_prdata_o  out  32  read data; 0 when pready low.
- apb_pslverr_o  out  1  error; valid only with pready high, else 0.
- clr_i  in  1  synchronous clear of all three counters.
- cnt_a_o / cnt_b_o / cnt_c_o  out  CNT_W  per-event counts.
- evt_o  out  3  one-cycle pulse {C,B,A} on a committed data write.

## Operation
- Register map per event base: +0x0 DATA (RW, 32 bit), +0x4 COUNT (RO, zero-extended to 32 bit). Any other address → error.
- Writes to DATA: store pwdata; increment the counter, saturating at all-ones; pulse evt_o.
- Writes to COUNT or any undecoded address: pslverr=1; no state change.
- Reads of DATA/COUNT return the value; undecoded reads → pslverr=1, prdata=0.
- FSM states: IDLE, ACCESS.
  - IDLE: on psel & !penable (setup phase), latch paddr/pwrite/pwdata, load wcnt=WAIT_CYCLES, go ACCESS.
  - ACCESS: if psel low, abort to IDLE with no commit (protocol violation). If wcnt≠0: pready=0 and decrement. If wcnt=0: pready=1 (psel & penable are required), commit at this edge, go IDLE.
- clr_i and a commit in the same cycle: the counter clears (clear wins); the DATA register is still written; evt_o still pulses.
- Reset values: FSM IDLE, wcnt 0, DATA regs 0, counters 0, pready 0, prdata 0, pslverr 0, evt_o 0.
- Reset asserted mid-transfer: the transfer is dropped with no commit, and all state is returned to reset values immediately.

## Timing
- A transfer is setup plus (WAIT_CYCLES+1) access cycles. With WAIT_CYCLES=0, pready is high in the first access cycle.
- pready, pslverr and prdata are decoded from registered state and the latched address only, with no combinational path from pwdata.
- cnt_*_o and DATA reflect a write in the cycle after the pready cycle. evt_o pulses in that same following cycle.
- Back-to-back transfers: the setup phase of the next transfer may occur in the cycle after pready, and is accepted from IDLE.

## Structure
- Package apb_event_pkg holds:
  - the EVENT_A/B/C base addresses;
  - the DATA/COUNT offsets;
  - the FSM state enum {IDLE, ACCESS}.
- The requester imports the same package for its address constants.
- Sub-module apb_event_reg, instantiated three times, holds the 32-bit DATA register and the CNT_W saturating counter. Its inputs are wr_en, wdata and clr; its outputs are data, cnt and evt.
- Top level holds the FSM, the wait counter, the address decode and the read mux.

## Test plan
- WAIT_CYCLES=1, write 0x1234_5678 to 0xABBA_0000 → pready high in the 2nd access cycle, pslverr 0, cnt_a_o=1 and evt_o=3'b001 in the next cycle.
- Read 0xBAFF_0004 after 3 writes to the B base → prdata=0x0000_0003, pslverr 0.
- CNT_W=2, 5 writes to 0xCAFE_0000 → cnt_c_o saturates at 3.
- Write to 0xCAFE_0004, then read 0xDEAD_0000 → both complete with pslverr=1, counters unchanged, prdata=0.
- clr_i asserted in the same cycle as the pready of a write to A (count 4 before) → cnt_a_o=0 and DATA updated.
- Reset asserted during the wait cycles of a write → no commit, pready=0, cnt_a_o=0; the next clean write completes normally.

Source files
------------

// File: rtl/apb_event_pkg.sv
// Shared constants for the event-notification APB segment: window bases,
// register offsets, completer FSM states and the address match helper.
package apb_event_pkg;

  localparam logic [31:0] EVENT_A_BASE = 32'hABBA_0000;
  localparam logic [31:0] EVENT_B_BASE = 32'hBAFF_0000;
  localparam logic [31:0] EVENT_C_BASE = 32'hCAFE_0000;

  localparam logic [31:0] DATA_OFS  = 32'h0000_0000;
  localparam logic [31:0] COUNT_OFS = 32'h0000_0004;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // One-hot {C,B,A} match of an address against one register offset.
  function automatic logic [2:0] match_reg(input logic [31:0] addr, input logic [31:0] ofs);
    match_reg = {addr == (EVENT_C_BASE + ofs),
                 addr == (EVENT_B_BASE + ofs),
                 addr == (EVENT_A_BASE + ofs)};
  endfunction

endpackage

// File: rtl/apb_event_reg.sv
// Per-event storage: last written payload, saturating write count and a
// one-cycle event pulse that lines up with the register update.
module apb_event_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [31:0]      wdata,
  input  logic             clr,
  output logic [31:0]      data,
  output logic [CNT_W-1:0] cnt,
  output logic             evt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
      cnt  <= '0;
      evt  <= 1'b0;
    end else begin
      evt <= wr_en;
      if (wr_en) data <= wdata;
      // Clear has priority over a simultaneous commit; the payload still lands.
      if (clr) begin
        cnt <= '0;
      end else if (wr_en && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/apb_event_sink.sv
// APB3 completer for the three event windows: FSM with programmable wait
// states, address decode, read mux and three per-event register slices.
module apb_event_sink
  import apb_event_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             apb_psel_i,
  input  logic             apb_penable_i,
  input  logic [31:0]      apb_paddr_i,
  input  logic             apb_pwrite_i,
  input  logic [31:0]      apb_pwdata_i,
  output logic             apb_pready_o,
  output logic [31:0]      apb_prdata_o,
  output logic             apb_pslverr_o,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_a_o,
  output logic [CNT_W-1:0] cnt_b_o,
  output logic [CNT_W-1:0] cnt_c_o,
  output logic [2:0]       evt_o,
  output state_e           dbg_state
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  // Handshake: a transfer is accepted from IDLE on psel & !penable; it
  // completes (and commits) on the edge where pready, psel and penable are
  // all high. Dropping psel during ACCESS abandons the transfer.
  state_e      state;
  logic [3:0]  wcnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic        pready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wcnt     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      pready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (apb_psel_i && !apb_penable_i) begin
            addr_q   <= apb_paddr_i;
            write_q  <= apb_pwrite_i;
            wdata_q  <= apb_pwdata_i;
            wcnt     <= WAIT_INIT;
            pready_q <= (WAIT_INIT == 4'd0);
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!apb_psel_i) begin
            wcnt     <= '0;
            pready_q <= 1'b0;
            state    <= IDLE;
          end else if (wcnt != 4'd0) begin
            wcnt     <= wcnt - 4'd1;
            pready_q <= (wcnt == 4'd1);
          end else begin
            pready_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [2:0]       hit_data;
  logic [2:0]       hit_cnt;
  logic             addr_ok;
  logic             complete;
  logic [2:0]       wr_en;
  logic [31:0]      data_q [3];
  logic [CNT_W-1:0] cnt_q  [3];
  logic [2:0]       evt_q;
  logic [31:0]      rd_val;

  assign hit_data = match_reg(addr_q, DATA_OFS);
  assign hit_cnt  = match_reg(addr_q, COUNT_OFS);
  // COUNT is read-only, so a write to it is treated like an undecoded hit.
  assign addr_ok  = (|hit_data) | ((|hit_cnt) & ~write_q);
  assign complete = pready_q & apb_psel_i & apb_penable_i;
  assign wr_en    = {3{complete & write_q}} & hit_data;

  for (genvar i = 0; i < 3; i++) begin : g_evt
    apb_event_reg #(.CNT_W(CNT_W)) u_reg (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en[i]),
      .wdata (wdata_q),
      .clr   (clr_i),
      .data  (data_q[i]),
      .cnt   (cnt_q[i]),
      .evt   (evt_q[i])
    );
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < 3; i++) begin
      if (hit_data[i]) rd_val = data_q[i];
      if (hit_cnt[i])  rd_val = 32'(cnt_q[i]);
    end
  end

  assign apb_pready_o  = pready_q;
  assign apb_pslverr_o = pready_q & ~addr_ok;
  assign apb_prdata_o  = (pready_q && !write_q && addr_ok) ? rd_val : 32'h0;
  assign cnt_a_o       = cnt_q[0];
  assign cnt_b_o       = cnt_q[1];
  assign cnt_c_o       = cnt_q[2];
  assign evt_o         = evt_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_apb_event_sink.sv
// Directed bench for apb_event_sink: a WAIT_CYCLES=1 instance driven from a
// vector table, and a WAIT_CYCLES=0 / CNT_W=2 instance for counter saturation.
module tb_apb_event_sink;
  import apb_event_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  psel = 2'b00;
  logic        penable = 1'b0;
  logic [31:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        clr = 1'b0;

  logic        pready0, pslverr0, pready1, pslverr1;
  logic [31:0] prdata0, prdata1;
  logic [15:0] cnt_a0, cnt_b0, cnt_c0;
  logic [1:0]  cnt_a1, cnt_b1, cnt_c1;
  logic [2:0]  evt0, evt1;
  state_e      state0, state1;

  always #5 clk = ~clk;

  apb_event_sink #(.WAIT_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .apb_psel_i(psel[0]), .apb_penable_i(penable),
    .apb_paddr_i(paddr), .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
    .apb_pready_o(pready0), .apb_prdata_o(prdata0), .apb_pslverr_o(pslverr0),
    .clr_i(clr), .cnt_a_o(cnt_a0), .cnt_b_o(cnt_b0), .cnt_c_o(cnt_c0),
    .evt_o(evt0), .dbg_state(state0)
  );

  apb_event_sink #(.WAIT_CYCLES(0), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .apb_psel_i(psel[1]), .apb_penable_i(penable),
    .apb_paddr_i(paddr), .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
    .apb_pready_o(pready1), .apb_prdata_o(prdata1), .apb_pslverr_o(pslverr1),
    .clr_i(clr), .cnt_a_o(cnt_a1), .cnt_b_o(cnt_b1), .cnt_c_o(cnt_c1),
    .evt_o(evt1), .dbg_state(state1)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Full APB transfer on instance d; returns at posedge+1 of the cycle after pready.
  task automatic apb_xfer(input int d, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, input logic clr_on_ready,
                          output logic [31:0] rd, output logic err, output int acc);
    logic rdy;
    @(posedge clk); #1;
    psel[d] = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    acc = 0; rd = '0; err = 1'b0;
    forever begin
      acc++;
      @(negedge clk);
      rdy = (d == 0) ? pready0 : pready1;
      if (rdy) begin
        rd  = (d == 0) ? prdata0 : prdata1;
        err = (d == 0) ? pslverr0 : pslverr1;
        clr = clr_on_ready;
        break;
      end
      if (acc > 20) begin
        check("pready_timeout", 32'(acc), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable = 1'b0; clr = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        clr;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] ca, cb, cc;
    logic [2:0]  evt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic        err;
    int          acc;

    vecs.push_back(vec_t'{32'hABBA_0000, 1'b1, 32'h1234_5678, 1'b0, 32'h0,          1'b0, 16'd1, 16'd0, 16'd0, 3'b001});
    vecs.push_back(vec_t'{32'hABBA_0000, 1'b0, 32'h0,         1'b0, 32'h1234_5678, 1'b0, 16'd1, 16'd0, 16'd0, 3'b000});
    vecs.push_back(vec_t'{32'hBAFF_0000, 1'b1, 32'h11,        1'b0, 32'h0,          1'b0, 16'd1, 16'd1, 16'd0, 3'b010});
    vecs.push_back(vec_t'{32'hBAFF_0000, 1'b1, 32'h22,        1'b0, 32'h0,          1'b0, 16'd1, 16'd2, 16'd0, 3'b010});
    vecs.push_back(vec_t'{32'hBAFF_0000, 1'b1, 32'h33,        1'b0, 32'h0,          1'b0, 16'd1, 16'd3, 16'd0, 3'b010});
    vecs.push_back(vec_t'{32'hBAFF_0004, 1'b0, 32'h0,         1'b0, 32'h0000_0003, 1'b0, 16'd1, 16'd3, 16'd0, 3'b000});
    vecs.push_back(vec_t'{32'hCAFE_0004, 1'b1, 32'h99,        1'b0, 32'h0,          1'b1, 16'd1, 16'd3, 16'd0, 3'b000});
    vecs.push_back(vec_t'{32'hDEAD_0000, 1'b0, 32'h0,         1'b0, 32'h0,          1'b1, 16'd1, 16'd3, 16'd0, 3'b000});
    vecs.push_back(vec_t'{32'hCAFE_0000, 1'b1, 32'h00C0_FFEE, 1'b0, 32'h0,          1'b0, 16'd1, 16'd3, 16'd1, 3'b100});
    vecs.push_back(vec_t'{32'hCAFE_0000, 1'b0, 32'h0,         1'b0, 32'h00C0_FFEE, 1'b0, 16'd1, 16'd3, 16'd1, 3'b000});
    vecs.push_back(vec_t'{32'hBAFF_0000, 1'b0, 32'h0,         1'b0, 32'h0000_0033, 1'b0, 16'd1, 16'd3, 16'd1, 3'b000});
    vecs.push_back(vec_t'{32'hABBA_0004, 1'b0, 32'h0,         1'b0, 32'h0000_0001, 1'b0, 16'd1, 16'd3, 16'd1, 3'b000});
    vecs.push_back(vec_t'{32'hABBA_0008, 1'b1, 32'h7,         1'b0, 32'h0,          1'b1, 16'd1, 16'd3, 16'd1, 3'b000});
    vecs.push_back(vec_t'{32'hABBA_0000, 1'b1, 32'h2,         1'b0, 32'h0,          1'b0, 16'd2, 16'd3, 16'd1, 3'b001});
    vecs.push_back(vec_t'{32'hABBA_0000, 1'b1, 32'h3,         1'b0, 32'h0,          1'b0, 16'd3, 16'd3, 16'd1, 3'b001});
    vecs.push_back(vec_t'{32'hABBA_0000, 1'b1, 32'h4,         1'b0, 32'h0,          1'b0, 16'd4, 16'd3, 16'd1, 3'b001});
    vecs.push_back(vec_t'{32'hABBA_0000, 1'b1, 32'hAAAA_5555, 1'b1, 32'h0,          1'b0, 16'd0, 16'd0, 16'd0, 3'b001});
    vecs.push_back(vec_t'{32'hABBA_0000, 1'b0, 32'h0,         1'b0, 32'hAAAA_5555, 1'b0, 16'd0, 16'd0, 16'd0, 3'b000});
    vecs.push_back(vec_t'{32'hBAFF_0004, 1'b0, 32'h0,         1'b0, 32'h0,          1'b0, 16'd0, 16'd0, 16'd0, 3'b000});
    vecs.push_back(vec_t'{32'hABBA_0000, 1'b1, 32'h5,         1'b0, 32'h0,          1'b0, 16'd1, 16'd0, 16'd0, 3'b001});

    // Clock/reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_pready", 32'(pready0), 32'd0);
    check("reset_prdata", prdata0, 32'd0);
    check("reset_pslverr", 32'(pslverr0), 32'd0);
    check("reset_cnt_a", 32'(cnt_a0), 32'd0);
    check("reset_evt", 32'(evt0), 32'd0);
    check("reset_state", 32'(state0), 32'(IDLE));
    reset = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      apb_xfer(0, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].clr, rd, err, acc);
      check($sformatf("v%0d_access_cycles", i), 32'(acc), 32'd2);
      check($sformatf("v%0d_pslverr", i), 32'(err), 32'(vecs[i].err));
      if (!vecs[i].wr) check($sformatf("v%0d_prdata", i), rd, vecs[i].rdata);
      check($sformatf("v%0d_cnt_a", i), 32'(cnt_a0), 32'(vecs[i].ca));
      check($sformatf("v%0d_cnt_b", i), 32'(cnt_b0), 32'(vecs[i].cb));
      check($sformatf("v%0d_cnt_c", i), 32'(cnt_c0), 32'(vecs[i].cc));
      check($sformatf("v%0d_evt", i), 32'(evt0), 32'(vecs[i].evt));
    end

    // Saturation on the 2-bit counter, zero wait states
    for (int k = 1; k <= 5; k++) exp_q.push_back((k < 3) ? 32'(k) : 32'd3);
    for (int k = 0; k < 5; k++) begin
      apb_xfer(1, 32'hCAFE_0000, 1'b1, 32'(k), 1'b0, rd, err, acc);
      check($sformatf("sat%0d_access_cycles", k), 32'(acc), 32'd1);
      check($sformatf("sat%0d_cnt_c", k), 32'(cnt_c1), exp_q.pop_front());
      check($sformatf("sat%0d_evt", k), 32'(evt1), 32'b100);
    end

    // Reset during the wait cycle of a write to A (count 1 before)
    @(posedge clk); #1;
    psel[0] = 1'b1; penable = 1'b0; paddr = 32'hABBA_0000; pwrite = 1'b1; pwdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("rst_mid_wait_pready", 32'(pready0), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_mid_pready", 32'(pready0), 32'd0);
    check("rst_mid_cnt_a", 32'(cnt_a0), 32'd0);
    check("rst_mid_evt", 32'(evt0), 32'd0);
    check("rst_mid_state", 32'(state0), 32'(IDLE));
    psel = 2'b00; penable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    apb_xfer(0, 32'hABBA_0000, 1'b0, 32'h0, 1'b0, rd, err, acc);
    check("post_rst_data_a", rd, 32'h0);
    check("post_rst_read_cnt_a", 32'(cnt_a0), 32'd0);
    apb_xfer(0, 32'hABBA_0000, 1'b1, 32'h0000_0077, 1'b0, rd, err, acc);
    check("post_rst_write_cycles", 32'(acc), 32'd2);
    check("post_rst_write_err", 32'(err), 32'd0);
    check("post_rst_cnt_a", 32'(cnt_a0), 32'd1);
    check("post_rst_evt", 32'(evt0), 32'b001);
    apb_xfer(0, 32'hABBA_0000, 1'b0, 32'h0, 1'b0, rd, err, acc);
    check("post_rst_readback", rd, 32'h0000_0077);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
